// File: rtl/snake_pkg.sv
// snake_pkg: shared playfield defaults, coordinate width, game-state codes and food FSM states.
package snake_pkg;
  localparam int GRID_W_DEF = 40;
  localparam int GRID_H_DEF = 30;
  localparam int COORD_W = 6;
  localparam logic [1:0] ST_PLAY = 2'b00;
  localparam logic [1:0] ST_OVER = 2'b10;
  typedef logic [COORD_W-1:0] coord_t;
  typedef enum logic [1:0] {IDLE, SPAWN, ACTIVE} fg_state_e;
endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] state_o
);
  logic [15:0] lfsr_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= SEED;
    else lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
  assign state_o = lfsr_q;
endmodule

// File: rtl/food_gen.sv
// food_gen: places food at pseudo-random free cells and pulses get_food when the head lands on it.
module food_gen
  import snake_pkg::*;
#(
  parameter int          GRID_W    = GRID_W_DEF,
  parameter int          GRID_H    = GRID_H_DEF,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         game_state,
  input  logic [COORD_W-1:0] head_x,
  input  logic [COORD_W-1:0] head_y,
  input  logic               head_valid,
  output logic [COORD_W-1:0] food_x,
  output logic [COORD_W-1:0] food_y,
  output logic               food_valid,
  output logic               get_food
);
  fg_state_e state_q, state_d;
  coord_t fx_q, fx_d, fy_q, fy_d;
  logic fv_q, fv_d, gf_q, gf_d;
  logic [15:0] lfsr;
  coord_t cand_x, cand_y;
  logic accept, hit, unused_lfsr;
  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst(rst), .state_o(lfsr));
  assign cand_x = lfsr[5:0];
  assign cand_y = lfsr[13:8];
  assign unused_lfsr = ^{lfsr[15:14], lfsr[7:6]};
  assign accept = ({1'b0, cand_x} < 7'(GRID_W)) && ({1'b0, cand_y} < 7'(GRID_H)) &&
                  !(cand_x == head_x && cand_y == head_y);
  assign hit = head_valid && head_x == fx_q && head_y == fy_q;
  // Pause codes (x1) fall through with every register held.
  always_comb begin
    state_d = state_q;
    fx_d = fx_q;
    fy_d = fy_q;
    fv_d = fv_q;
    gf_d = 1'b0;
    if (game_state == ST_OVER) begin
      state_d = IDLE;
      fv_d = 1'b0;
    end else if (game_state == ST_PLAY) begin
      case (state_q)
        IDLE: state_d = SPAWN;
        SPAWN: if (accept) begin
          fx_d = cand_x;
          fy_d = cand_y;
          fv_d = 1'b1;
          state_d = ACTIVE;
        end
        ACTIVE: if (hit) begin
          gf_d = 1'b1;
          fv_d = 1'b0;
          state_d = SPAWN;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      fx_q <= '0;
      fy_q <= '0;
      fv_q <= 1'b0;
      gf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fx_q <= fx_d;
      fy_q <= fy_d;
      fv_q <= fv_d;
      gf_q <= gf_d;
    end
  end
  assign food_x = fx_q;
  assign food_y = fy_q;
  assign food_valid = fv_q;
  assign get_food = gf_q;
endmodule
